// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide engine for the multicycle CPU: a WIDTH-step
// shift-add multiply or restoring divide on magnitudes, with signs applied at the end.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             write_hi,
    output logic             write_lo,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    typedef enum logic [2:0] {IDLE, RUN, FIX, DONE, DZERO} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc_hi, acc_lo, mag_b;
    logic               op_q, neg_q, sign_a_q;

    logic               b_zero;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_sub;
    logic               rem_ge;
    logic [2*WIDTH-1:0] prod, prod_neg;

    assign b_zero   = (b_in == '0);

    // Multiply: acc_hi collects partial sums while the multiplier shifts out of acc_lo.
    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);

    // Divide: acc_hi is the remainder, acc_lo the dividend turning into the quotient.
    // The shifted remainder needs one extra bit before the compare.
    assign rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
    assign rem_ge   = (rem_sh >= {1'b0, mag_b});
    assign rem_sub  = rem_sh[WIDTH-1:0] - mag_b;

    assign prod     = {acc_hi, acc_lo};
    assign prod_neg = -prod;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        div_zero = 1'b0;
        write_hi = 1'b0;
        write_lo = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = (op && b_zero) ? DZERO : RUN;
            RUN: begin
                busy = 1'b1;
                if (cnt == '0) state_nx = FIX;
            end
            FIX: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                write_hi = 1'b1;
                write_lo = 1'b1;
                state_nx = IDLE;
            end
            DZERO: begin
                busy     = 1'b1;
                done     = 1'b1;
                div_zero = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            mag_b    <= '0;
            op_q     <= 1'b0;
            neg_q    <= 1'b0;
            sign_a_q <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q     <= op;
                    sign_a_q <= a_in[WIDTH-1];
                    neg_q    <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                    acc_hi   <= '0;
                    acc_lo   <= a_in[WIDTH-1] ? -a_in : a_in;
                    mag_b    <= b_in[WIDTH-1] ? -b_in : b_in;
                    cnt      <= CNT_W'(WIDTH - 1);
                end
                RUN: begin
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                    if (op_q) begin
                        acc_hi <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], rem_ge};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    // Quotient truncates toward zero; remainder follows the dividend's sign.
                    if (op_q) begin
                        lo_out <= neg_q    ? -acc_lo : acc_lo;
                        hi_out <= sign_a_q ? -acc_hi : acc_hi;
                    end else begin
                        {hi_out, lo_out} <= neg_q ? prod_neg : prod;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
